// File: rtl/pipeline_muldiv_ex.sv
`default_nettype none
// ---------------------------------------------------------------------------
// pipeline_muldiv_ex : 34-cycle iterative multiply/divide unit owning HI/LO.
// Divider is built only when MULDIV_DIV_EN is defined.
// Revision: 1.0
// ---------------------------------------------------------------------------
module pipeline_muldiv_ex #(
  parameter int CYCLES = 32
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_dat,
  input  logic [31:0] rt_dat,
  input  logic        flush,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t      r_state, w_next;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_mcand;
  logic        r_neg_q;
  logic        r_done;
  logic [31:0] r_hi, r_lo;

  logic        w_signed, w_accept;
  logic [31:0] w_abs_a, w_abs_b;
  logic [32:0] w_sum;
  logic [63:0] w_prod_fix;
  logic [63:0] w_result;

  assign w_signed = ~op[0];
  assign w_abs_a  = (w_signed & rs_dat[31]) ? (32'd0 - rs_dat) : rs_dat;
  assign w_abs_b  = (w_signed & rt_dat[31]) ? (32'd0 - rt_dat) : rt_dat;

  // Shift-add step: upper half plus optional multiplicand, carry kept.
  assign w_sum      = {1'b0, r_acc[63:32]} + {1'b0, (r_acc[0] ? r_mcand : 32'd0)};
  assign w_prod_fix = r_neg_q ? (64'd0 - r_acc) : r_acc;

`ifdef MULDIV_DIV_EN
  logic        r_is_div;
  logic        r_neg_r;
  logic [32:0] r_rem;
  logic [33:0] w_diff;
  logic [31:0] w_q_fix, w_r_fix;

  assign w_accept = start & ~flush;
  // Top remainder bit is always 0 after a restore, so bit 33 is the borrow.
  assign w_diff   = {r_rem, r_acc[31]} - {2'b00, r_mcand};
  assign w_q_fix  = r_neg_q ? (32'd0 - r_acc[31:0]) : r_acc[31:0];
  assign w_r_fix  = r_neg_r ? (32'd0 - r_rem[31:0]) : r_rem[31:0];
  assign w_result = r_is_div ? {w_r_fix, w_q_fix} : w_prod_fix;
`else
  assign w_accept = start & ~flush & ~op[1];
  assign w_result = w_prod_fix;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_CALC;
      S_CALC:  if (r_cnt == 6'(CYCLES - 1)) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    if (flush) w_next = S_IDLE;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      r_cnt   <= 6'd0;
      r_acc   <= 64'd0;
      r_mcand <= 32'd0;
      r_neg_q <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
`ifdef MULDIV_DIV_EN
      r_is_div <= 1'b0;
      r_neg_r  <= 1'b0;
      r_rem    <= 33'd0;
`endif
    end else begin
      r_done <= (r_state == S_FIX) && !flush;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_cnt   <= 6'd0;
            r_neg_q <= w_signed & (rs_dat[31] ^ rt_dat[31]);
`ifdef MULDIV_DIV_EN
            r_is_div <= op[1];
            r_neg_r  <= w_signed & rs_dat[31];
            r_rem    <= 33'd0;
            // Divide: divisor in r_mcand, dividend shifts out of r_acc[31:0].
            r_mcand  <= op[1] ? w_abs_b : w_abs_a;
            r_acc    <= {32'd0, (op[1] ? w_abs_a : w_abs_b)};
`else
            r_mcand  <= w_abs_a;
            r_acc    <= {32'd0, w_abs_b};
`endif
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 6'd1;
`ifdef MULDIV_DIV_EN
          if (r_is_div) begin
            r_acc[31:0] <= {r_acc[30:0], ~w_diff[33]};
            r_rem       <= w_diff[33] ? {r_rem[31:0], r_acc[31]} : w_diff[32:0];
          end else begin
            r_acc <= {w_sum, r_acc[31:1]};
          end
`else
          r_acc <= {w_sum, r_acc[31:1]};
`endif
        end
        S_FIX: begin
          if (!flush) begin
            r_hi <= w_result[63:32];
            r_lo <= w_result[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_muldiv_ex.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_pipeline_muldiv_ex : directed self-checking bench for pipeline_muldiv_ex.
// Revision: 1.0
// ---------------------------------------------------------------------------
module tb_pipeline_muldiv_ex;

  logic        CLK, RST, start, flush;
  logic [1:0]  op;
  logic [31:0] rs_dat, rt_dat;
  logic        busy, done;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_pass   = 0;

  localparam logic [1:0] c_MULT = 2'b00, c_MULTU = 2'b01, c_DIV = 2'b10, c_DIVU = 2'b11;

  pipeline_muldiv_ex #(.CYCLES(32)) u_dut (
    .CLK(CLK), .RST(RST), .start(start), .op(op),
    .rs_dat(rs_dat), .rt_dat(rt_dat), .flush(flush),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
  endtask

  // Issue one op and follow it through the full 34-cycle window.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int nbusy = 0, ndone = 0, nchg = 0;
    logic [31:0] ph, pl;
    @(negedge CLK);
    ph = hi; pl = lo;
    start = 1'b1; op = o; rs_dat = a; rt_dat = b;
    for (int k = 1; k <= 33; k++) begin
      @(negedge CLK);
      start = 1'b0;
      if (busy) nbusy++;
      if (done) ndone++;
      if (hi !== ph || lo !== pl) nchg++;
    end
    chk({tag, "_busy_cycles"}, 64'(nbusy), 64'd33);
    chk({tag, "_early_done"}, 64'(ndone), 64'd0);
    chk({tag, "_hilo_hold"}, 64'(nchg), 64'd0);
    @(negedge CLK);
    chk({tag, "_busy_c34"}, 64'(busy), 64'd0);
    chk({tag, "_done_c34"}, 64'(done), 64'd1);
    chk({tag, "_hi"}, 64'(hi), 64'(eh));
    chk({tag, "_lo"}, 64'(lo), 64'(el));
    @(negedge CLK);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
  endtask

  // Issue a start that must be refused; nothing may happen afterwards.
  task automatic no_accept(input string tag, input logic [1:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic fl);
    int nbusy = 0, ndone = 0, nchg = 0;
    logic [31:0] ph, pl;
    @(negedge CLK);
    ph = hi; pl = lo;
    start = 1'b1; flush = fl; op = o; rs_dat = a; rt_dat = b;
    for (int k = 1; k <= 36; k++) begin
      @(negedge CLK);
      start = 1'b0; flush = 1'b0;
      if (busy) nbusy++;
      if (done) ndone++;
      if (hi !== ph || lo !== pl) nchg++;
    end
    chk({tag, "_busy"}, 64'(nbusy), 64'd0);
    chk({tag, "_done"}, 64'(ndone), 64'd0);
    chk({tag, "_hilo"}, 64'(nchg), 64'd0);
  endtask

  initial begin
    int ndone, nchg;
    RST = 1'b1; start = 1'b0; flush = 1'b0; op = 2'b00; rs_dat = '0; rt_dat = '0;
    repeat (2) @(negedge CLK);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_hi", 64'(hi), 64'd0);
    chk("rst_lo", 64'(lo), 64'd0);
    RST = 1'b0;

    run_op("multu_max", c_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op("mult_m3x7", c_MULT, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);
    run_op("mult_min2", c_MULT, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op("mult_minx1", c_MULT, 32'h8000_0000, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000);

`ifdef MULDIV_DIV_EN
    run_op("div_m7d2", c_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("div_7dm2", c_DIV, 32'd7, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
    run_op("divu_100d7", c_DIVU, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("divu_5d0", c_DIVU, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_ovf", c_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`else
    no_accept("divu_off", c_DIVU, 32'd10, 32'd3, 1'b0);
    run_op("multu_10x3", c_MULTU, 32'd10, 32'd3, 32'd0, 32'd30);
`endif

    // Flush mid-CALC
    run_op("preload", c_MULTU, 32'd2, 32'd3, 32'd0, 32'd6);
    @(negedge CLK);
    start = 1'b1; op = c_MULTU; rs_dat = 32'd9; rt_dat = 32'd9;
    for (int k = 1; k <= 9; k++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    @(negedge CLK);
    chk("flush_busy_c10", 64'(busy), 64'd1);
    flush = 1'b1;
    @(negedge CLK);
    flush = 1'b0;
    chk("flush_busy_c11", 64'(busy), 64'd0);
    ndone = 0; nchg = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (done) ndone++;
      if (lo !== 32'd6 || hi !== 32'd0) nchg++;
    end
    chk("flush_done", 64'(ndone), 64'd0);
    chk("flush_hilo", 64'(nchg), 64'd0);

    no_accept("flush_start", c_MULTU, 32'd9, 32'd9, 1'b1);

    // Asynchronous reset mid-CALC
    @(negedge CLK);
    start = 1'b1; op = c_MULTU; rs_dat = 32'd9; rt_dat = 32'd9;
    for (int k = 1; k <= 5; k++) begin
      @(negedge CLK);
      start = 1'b0;
    end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    #2 RST = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_hi", 64'(hi), 64'd0);
    chk("midrst_lo", 64'(lo), 64'd0);
    @(negedge CLK);
    RST = 1'b0;

    run_op("post_rst", c_MULTU, 32'd12, 32'd11, 32'd0, 32'd132);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running, expected finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/pipeline_muldiv_ex.md
# pipeline_muldiv_ex

Iterative multiply/divide unit alongside the execute stage of the five-stage pipeline. It consumes operand data and a multiply/divide op straight from the decode/execute latch outputs and runs in the background over 34 cycles. It owns the architectural HI/LO registers. The hazard unit reads `busy` to stall only instructions that need HI/LO (MFHI, MFLO, or a new mult/div) until the result is ready.

## Interface
Parameters:
- `CYCLES`, default 32: iteration count. Equals the operand width; the unit is fixed at 32-bit.

Ports:
- `CLK` in, 1: pipeline clock.
- `RST` in, 1: asynchronous, active-high reset.
- `start` in, 1: a mult/div op is valid in EX this cycle.
- `op` in, 2: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
- `rs_dat` in, 32: forwarded rs value; multiplicand or dividend.
- `rt_dat` in, 32: forwarded rt value; multiplier or divisor.
- `flush` in, 1: squash any in-flight op.
- `busy` out, 1: an op is in flight; HI/LO are not yet valid.
- `done` out, 1: one-cycle pulse; HI/LO were updated on the previous edge.
- `hi` out, 32: HI register.
- `lo` out, 32: LO register.

## Operation
- States: IDLE, CALC, FIX.
- IDLE, `start`=1, `flush`=0, op accepted:
  - Latch the operand magnitudes. For signed ops use the two's-complement absolute value; 0x8000_0000 stays 0x8000_0000 as an unsigned magnitude.
  - Latch the result sign: XOR of the operand signs for the product and quotient; the dividend sign for the remainder.
  - Clear the 6-bit counter and go to CALC.
- CALC, multiply: radix-2 shift-add into a 64-bit accumulator, one multiplier bit per cycle, LSB first.
- CALC, divide: restoring division, one quotient bit per cycle. Uses a 33-bit partial remainder to absorb the subtract borrow.
- CALC exits to FIX when the counter reaches `CYCLES`-1.
- FIX: apply the sign correction by negation, write HI/LO, set `done`, go to IDLE.
  - Multiply: HI = product[63:32], LO = product[31:0].
  - Divide: LO = quotient, HI = remainder.
- Divide by zero needs no special casing; the natural restoring result is required:
  - DIVU: LO = 0xFFFF_FFFF, HI = rs_dat.
  - DIV: the signed fix-up is applied to the same raw values.
- Signed overflow, DIV 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
- `start` while not IDLE is ignored. The hazard unit must not issue it.
- `flush` in any state: next state IDLE, `done` = 0, HI/LO unchanged, no result written.
- `flush` and `start` in the same cycle: flush wins, the op is not accepted.
- `RST` mid-operation: immediate return to IDLE; HI/LO cleared.

## Timing
- Reset values: state IDLE, `busy`=0, `done`=0, `hi`=0, `lo`=0; counter and datapath registers 0.
- `busy` = (state != IDLE). It is decoded from the registered state and has no combinational path from `start`.
- `done` is registered.
- Cycle 0: `start` sampled high in IDLE.
- Cycles 1–32: CALC, `busy`=1.
- Cycle 33: FIX, `busy`=1.
- Edge ending cycle 33: HI/LO written.
- Cycle 34: `busy`=0, `done`=1, new `hi`/`lo` visible, and a new `start` may be accepted.
- Total latency from accept to visible result: 34 cycles. Throughput: one op per 34 cycles.
- `hi`/`lo` hold their value at all times except on the single FIX edge.

## Configuration
- `MULDIV_DIV_EN` defined:
  - DIV and DIVU are implemented as above.
- `MULDIV_DIV_EN` undefined:
  - The divider datapath and the 33-bit remainder register are compiled out.
  - `start` with `op`[1]=1 is not accepted: state stays IDLE, `busy` stays 0, no `done`, HI/LO unchanged.
  - MULT and MULTU are unaffected.

## Test plan
- Reset, then MULTU 0xFFFF_FFFF × 0xFFFF_FFFF:
  - `busy` high in cycles 1–33.
  - `done` in cycle 34 with HI = 0xFFFF_FFFE, LO = 0x0000_0001.
- MULT 0xFFFF_FFFD (−3) × 7:
  - HI = 0xFFFF_FFFF, LO = 0xFFFF_FFEB (−21).
- DIV −7 / 2 (with `MULDIV_DIV_EN`):
  - LO = 0xFFFF_FFFD (−3), HI = 0xFFFF_FFFF (−1).
- Corner divides:
  - DIVU 5 / 0: LO = 0xFFFF_FFFF, HI = 5.
  - DIV 0x8000_0000 / −1: LO = 0x8000_0000, HI = 0.
- Flush and reset mid-operation:
  - Preload HI/LO via MULTU 2×3 (HI = 0, LO = 6).
  - Start MULTU 9×9, assert `flush` in cycle 10: `busy` = 0 in cycle 11, no `done`, LO stays 6.
  - Assert `flush` together with `start`: op not accepted.
  - Assert `RST` mid-CALC: `hi`/`lo`/`busy` = 0 immediately.
- Build without `MULDIV_DIV_EN`, start DIVU 10/3:
  - `busy` stays 0, no `done`, HI/LO unchanged.
  - A following MULTU 10×3 gives LO = 30 in cycle 34.
